// File: rtl/i2c_master.sv
// Byte-level I2C master: one START/WRITE/READ/STOP command in, one response out.
// Drives open-drain SCL/SDA enables in four quarter-bit phases of CLK_DIV clocks each.
module i2c_master #(
    parameter int CLK_DIV = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic [2:0] state_dbg
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    logic [2:0]    state_q, state_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          is_read_q, is_read_d;
    logic          nack_q, nack_d;
    logic          ack_bit_q, ack_bit_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          sync1_q, sync2_q;
    logic          phase_end;
    logic          bit_val;

    // Handshake: a command is taken on any edge with cmd_valid & cmd_ready; cmd_ready is
    // high only in IDLE, so it is high again in the cycle rsp_valid pulses.
    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rd_data   = rd_data_q;
    assign ack_err   = ack_err_q;
    assign busy      = busy_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        phase_cnt_d = phase_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        is_read_d   = is_read_q;
        nack_d      = nack_q;
        ack_bit_d   = ack_bit_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        ack_err_d   = ack_err_q;
        rd_data_d   = rd_data_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        phase_end   = (phase_cnt_q == PHASE_LAST);

        if (state_q == S_IDLE) begin
            if (cmd_valid) begin
                phase_cnt_d = '0;
                quarter_d   = 2'd0;
                bit_cnt_d   = 3'd0;
                case (cmd)
                    CMD_START: state_d = S_START;
                    CMD_STOP: begin
                        if (busy_q) begin
                            state_d = S_STOP;
                        end else begin
                            rsp_valid_d = 1'b1;
                            ack_err_d   = 1'b0;
                        end
                    end
                    default: begin
                        if (busy_q) begin
                            state_d   = S_BIT;
                            shift_d   = wr_data;
                            is_read_d = (cmd == CMD_READ);
                            nack_d    = rd_nack;
                        end else begin
                            rsp_valid_d = 1'b1;
                            ack_err_d   = 1'b1;
                        end
                    end
                endcase
            end
        end else begin
            phase_cnt_d = phase_end ? '0 : phase_cnt_q + 1'b1;
            if (phase_end) quarter_d = quarter_q + 2'd1;
            // SCL has been high for a full phase by the end of P2: sample there.
            if (phase_end && quarter_q == 2'd2) begin
                if (state_q == S_BIT && is_read_q) shift_d = {shift_q[6:0], sync2_q};
                if (state_q == S_ACK) ack_bit_d = sync2_q;
            end
            if (phase_end && quarter_q == 2'd3) begin
                if (state_q == S_BIT) begin
                    if (bit_cnt_q == 3'd7) state_d = S_ACK;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    ack_err_d   = (state_q == S_ACK) && !is_read_q && ack_bit_q;
                    if (state_q == S_ACK && is_read_q) rd_data_d = shift_q;
                end
            end
        end

        // Line enables are registered from the next state so the pads never glitch.
        bit_val = shift_d[3'd7 - bit_cnt_d];
        case (state_d)
            S_START: begin
                case (quarter_d)
                    2'd0: sda_oe_d = 1'b0;
                    2'd1: scl_oe_d = 1'b0;
                    2'd2: begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                    default: scl_oe_d = 1'b1;
                endcase
            end
            S_BIT, S_ACK: begin
                case (quarter_d)
                    2'd0: begin
                        scl_oe_d = 1'b1;
                        if (state_d == S_ACK) sda_oe_d = is_read_d & ~nack_d;
                        else sda_oe_d = ~is_read_d & ~bit_val;
                    end
                    2'd3:    scl_oe_d = 1'b1;
                    default: scl_oe_d = 1'b0;
                endcase
            end
            S_STOP: begin
                case (quarter_d)
                    2'd0: begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end
                    2'd1: scl_oe_d = 1'b0;
                    2'd2: sda_oe_d = 1'b0;
                    default: begin
                        scl_oe_d = 1'b0;
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            quarter_q   <= 2'd0;
            phase_cnt_q <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            is_read_q   <= 1'b0;
            nack_q      <= 1'b0;
            ack_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            ack_err_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            is_read_q   <= is_read_d;
            nack_q      <= nack_d;
            ack_bit_q   <= ack_bit_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            ack_err_q   <= ack_err_d;
            rd_data_q   <= rd_data_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            sync1_q     <= sda_in;
            sync2_q     <= sync1_q;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with CLK_DIV=2: a command table plus hand-written
// sequences for busy-time cmd_valid pulses and reset in the middle of a READ.
module tb_i2c_master;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       rd_nack = 1'b0;
  logic       cmd_ready, rsp_valid, ack_err, busy, scl_oe, sda_oe, sda_in;
  logic [7:0] rd_data;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;

  // slave model: mode 0 silent, 1 ACKs a written byte, 2 sends slave_byte
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         slave_idx;
  logic       slave_pull;
  logic       scl_prev_b = 1'b0;
  logic [7:0] slave_sh;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] wr;
    logic       nack;
    int         mode;
    logic [7:0] sbyte;
    int         exp_cyc;
    logic       exp_err;
    logic       exp_busy;
    logic       exp_scl;
    logic       exp_sda;
    logic [7:0] exp_rd;
    int         exp_nb;
    logic [8:0] exp_bits;
    logic       exp_stop;
  } vec_t;

  vec_t vecs[$];

  i2c_master #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .wr_data(wr_data),
    .rd_nack(rd_nack), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rd_data(rd_data),
    .ack_err(ack_err), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    scl_prev_b <= scl_oe;
    if (scl_oe && !scl_prev_b) fall_cnt <= fall_cnt + 1;
  end

  always_comb begin
    slave_idx = fall_cnt - fall_base;
    slave_pull = 1'b0;
    slave_sh = 8'h00;
    if (slave_mode == 1) begin
      slave_pull = (slave_idx == 8);
    end else if (slave_mode == 2 && slave_idx >= 0 && slave_idx < 8) begin
      slave_sh = slave_byte << slave_idx;
      slave_pull = ~slave_sh[7];
    end
  end

  assign sda_in = ~sda_oe & ~slave_pull;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [7:0] wr, input logic nack,
                              input int mode, input logic [7:0] sb, input int cyc,
                              input logic err, input logic bsy, input logic scl,
                              input logic sda, input logic [7:0] rd, input int nb,
                              input logic [8:0] bits, input logic stp);
    vec_t v;
    v.cmd = c; v.wr = wr; v.nack = nack; v.mode = mode; v.sbyte = sb;
    v.exp_cyc = cyc; v.exp_err = err; v.exp_busy = bsy; v.exp_scl = scl; v.exp_sda = sda;
    v.exp_rd = rd; v.exp_nb = nb; v.exp_bits = bits; v.exp_stop = stp;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int cyc = 0;
    int nb = 0;
    logic [8:0] bits = 9'h000;
    logic got = 1'b0;
    logic saw_stop = 1'b0;
    logic prev_scl, prev_sda;
    logic r_ready = 1'b0, r_err = 1'b0, r_busy = 1'b0, r_scl = 1'b0, r_sda = 1'b0;
    logic [7:0] r_rd = 8'h00;
    @(negedge clk);
    slave_mode = v.mode;
    slave_byte = v.sbyte;
    fall_base = fall_cnt;
    cmd = v.cmd; wr_data = v.wr; rd_nack = v.nack; cmd_valid = 1'b1;
    prev_scl = scl_oe;
    prev_sda = sda_oe;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      if (cyc == 1) check($sformatf("v%0d ready_after_accept", id), cmd_ready, v.exp_cyc == 1);
      if (prev_scl && !scl_oe && nb < 9) begin
        bits[8-nb] = ~sda_oe & ~slave_pull;
        nb++;
      end
      if (prev_sda && !sda_oe && !prev_scl && !scl_oe) saw_stop = 1'b1;
      prev_scl = scl_oe;
      prev_sda = sda_oe;
      if (rsp_valid) begin
        got = 1'b1;
        r_ready = cmd_ready; r_err = ack_err; r_busy = busy;
        r_scl = scl_oe; r_sda = sda_oe; r_rd = rd_data;
      end
    end
    check($sformatf("v%0d rsp_cycle", id), cyc, v.exp_cyc);
    check($sformatf("v%0d ack_err", id), r_err, v.exp_err);
    check($sformatf("v%0d ready_at_rsp", id), r_ready, 1'b1);
    check($sformatf("v%0d busy", id), r_busy, v.exp_busy);
    check($sformatf("v%0d scl_oe", id), r_scl, v.exp_scl);
    check($sformatf("v%0d sda_oe", id), r_sda, v.exp_sda);
    check($sformatf("v%0d rd_data", id), r_rd, v.exp_rd);
    check($sformatf("v%0d stop_edge", id), saw_stop, v.exp_stop);
    if (v.exp_nb > 0) begin
      check($sformatf("v%0d nbits", id), nb, v.exp_nb);
      check($sformatf("v%0d sda_bits", id), bits, v.exp_bits);
    end
  endtask

  initial begin
    int rsp_cnt;
    int n;
    //             cmd      wr     nk md sbyte  cyc err bsy scl sda rd     nb bits           stop
    vecs.push_back(mk(C_WRITE, 8'h55, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 9'h000, 0));
    vecs.push_back(mk(C_STOP,  8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 9'h000, 0));
    vecs.push_back(mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'h00, 0, 9'h000, 0));
    vecs.push_back(mk(C_WRITE, 8'h3A, 0, 1, 8'h00, 73, 0, 1, 1, 0, 8'h00, 9, {8'h3A, 1'b0}, 0));
    vecs.push_back(mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'h00, 0, 9'h000, 0));
    vecs.push_back(mk(C_WRITE, 8'h3B, 0, 1, 8'h00, 73, 0, 1, 1, 0, 8'h00, 9, {8'h3B, 1'b0}, 0));
    vecs.push_back(mk(C_READ,  8'h00, 1, 2, 8'hE5, 73, 0, 1, 1, 0, 8'hE5, 9, {8'hE5, 1'b1}, 0));
    vecs.push_back(mk(C_STOP,  8'h00, 0, 0, 8'h00, 9, 0, 0, 0, 0, 8'hE5, 0, 9'h000, 1));
    vecs.push_back(mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'hE5, 0, 9'h000, 0));
    vecs.push_back(mk(C_WRITE, 8'h3A, 0, 0, 8'h00, 73, 1, 1, 1, 0, 8'hE5, 9, {8'h3A, 1'b1}, 0));
    vecs.push_back(mk(C_STOP,  8'h00, 0, 0, 8'h00, 9, 0, 0, 0, 0, 8'hE5, 0, 9'h000, 1));
    vecs.push_back(mk(C_READ,  8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'hE5, 0, 9'h000, 0));
    vecs.push_back(mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'hE5, 0, 9'h000, 0));
    vecs.push_back(mk(C_WRITE, 8'h3B, 0, 1, 8'h00, 73, 0, 1, 1, 0, 8'hE5, 9, {8'h3B, 1'b0}, 0));
    vecs.push_back(mk(C_READ,  8'h00, 0, 2, 8'h5C, 73, 0, 1, 1, 1, 8'h5C, 9, {8'h5C, 1'b0}, 0));
    vecs.push_back(mk(C_STOP,  8'h00, 0, 0, 8'h00, 9, 0, 0, 0, 0, 8'h5C, 0, 9'h000, 1));

    // clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset scl_oe", scl_oe, 1'b0);
    check("reset sda_oe", sda_oe, 1'b0);
    check("reset cmd_ready", cmd_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rd_data", rd_data, 8'h00);
    check("reset ack_err", ack_err, 1'b0);
    check("reset state", state_dbg, 3'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // cmd_valid pulses while a START is in flight must be ignored
    @(negedge clk);
    slave_mode = 0;
    cmd = C_START; cmd_valid = 1'b1;
    rsp_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cmd = C_STOP;
      cmd_valid = (k >= 2 && k <= 7);
      if (rsp_valid) rsp_cnt++;
    end
    check("busy pulses rsp count", rsp_cnt, 1);
    check("busy pulses busy", busy, 1'b1);
    run_vec(100, mk(C_STOP, 8'h00, 0, 0, 8'h00, 9, 0, 0, 0, 0, 8'h5C, 0, 9'h000, 1));

    // reset during bit 4 of a READ
    run_vec(101, mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'h5C, 0, 9'h000, 0));
    @(negedge clk);
    slave_mode = 2; slave_byte = 8'hA6; fall_base = fall_cnt;
    cmd = C_READ; rd_nack = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((fall_cnt - fall_base) < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid-read reached bit4", fall_cnt - fall_base, 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst scl_oe", scl_oe, 1'b0);
    check("mid rst sda_oe", sda_oe, 1'b0);
    check("mid rst cmd_ready", cmd_ready, 1'b1);
    check("mid rst busy", busy, 1'b0);
    check("mid rst rd_data", rd_data, 8'h00);
    check("mid rst state", state_dbg, 3'd0);
    rst = 1'b0;
    slave_mode = 0;
    run_vec(102, mk(C_START, 8'h00, 0, 0, 8'h00, 9, 0, 1, 1, 1, 8'h00, 0, 9'h000, 0));
    run_vec(103, mk(C_STOP,  8'h00, 0, 0, 8'h00, 9, 0, 0, 0, 0, 8'h00, 0, 9'h000, 1));

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
